axil_charge_resp: RTL and testbench

AXIL_CHARGE_RESP -- requirements
Module: axil_charge_resp

---
 rtl/chg_pkg.sv | 36 +++
 rtl/chg_regfile.sv | 117 +++++++++++
 rtl/axil_charge_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_axil_charge_resp.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chg_pkg.sv
// Shared definitions for the charge-balance register block: response codes,
// special word indices, FSM state types and the byte-strobe merge helper.
package chg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned LIMIT_IDX = 16;
    localparam int unsigned VCNT_IDX  = 17;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Replace each byte of old_val whose strobe bit is set with the new byte.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/chg_regfile.sv
// Charge-balance storage: BAL[0..N_ENTRIES-1] and LIMIT, with the byte merge,
// address decode for both ports and the optional over-limit policy check.
// Optional feature: CHG_POLICY_CHECK_EN rejects BAL writes whose merged value
// exceeds LIMIT (unsigned).
module chg_regfile
    import chg_pkg::*;
#(
    parameter int          N_ENTRIES = 16,
    parameter logic [31:0] LIMIT_RST = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // write port: wr_en_i marks the commit cycle of an AXI write
    input  logic        wr_en_i,
    input  logic [5:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    output logic [1:0]  wr_resp_o,
    output logic        violation_o,
    // read port: combinational view of the current (pre-commit) contents
    input  logic [5:0]  rd_idx_i,
    input  logic [15:0] vcnt_i,
    output logic [31:0] rd_data_o,
    output logic [1:0]  rd_resp_o
);

    localparam int          IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [5:0]  NUM_BAL  = 6'(N_ENTRIES);
    localparam logic [5:0]  LIMIT_W6 = 6'(LIMIT_IDX);
    localparam logic [5:0]  VCNT_W6  = 6'(VCNT_IDX);

    logic [31:0] bal_q [N_ENTRIES];
    logic [31:0] limit_q;

    logic             wr_is_bal, wr_is_limit, wr_is_vcnt;
    logic             rd_is_bal, rd_is_limit, rd_is_vcnt;
    logic [IDX_W-1:0] wr_bal_idx, rd_bal_idx;
    logic [31:0]      wr_old, wr_merged;
    logic             bal_we, limit_we;

    // Words between N_ENTRIES and LIMIT_IDX are unmapped and decode as DECERR.
    assign wr_is_bal   = (wr_idx_i < NUM_BAL);
    assign wr_is_limit = (wr_idx_i == LIMIT_W6);
    assign wr_is_vcnt  = (wr_idx_i == VCNT_W6);
    assign rd_is_bal   = (rd_idx_i < NUM_BAL);
    assign rd_is_limit = (rd_idx_i == LIMIT_W6);
    assign rd_is_vcnt  = (rd_idx_i == VCNT_W6);
    assign wr_bal_idx  = wr_idx_i[IDX_W-1:0];
    assign rd_bal_idx  = rd_idx_i[IDX_W-1:0];

    // Select the current value of the write target so strobes can merge into it.
    always_comb begin
        wr_old = '0;
        if (wr_is_bal) begin
            wr_old = bal_q[wr_bal_idx];
        end else if (wr_is_limit) begin
            wr_old = limit_q;
        end
    end

    assign wr_merged = strb_merge(wr_old, wr_data_i, wr_strb_i);

    // Decide the write response, the storage enables and the policy verdict.
    always_comb begin
        wr_resp_o   = RESP_DECERR;
        violation_o = 1'b0;
        bal_we      = 1'b0;
        limit_we    = 1'b0;
        if (wr_is_bal) begin
            wr_resp_o = RESP_OKAY;
            bal_we    = wr_en_i;
`ifdef CHG_POLICY_CHECK_EN
            // An all-zero strobe never changes the word, so it is never a violation.
            if ((wr_strb_i != 4'b0000) && (wr_merged > limit_q)) begin
                wr_resp_o   = RESP_SLVERR;
                violation_o = wr_en_i;
                bal_we      = 1'b0;
            end
`endif
        end else if (wr_is_limit) begin
            wr_resp_o = RESP_OKAY;
            limit_we  = wr_en_i;
        end else if (wr_is_vcnt) begin
            wr_resp_o = RESP_SLVERR;
        end
    end

    // Storage update on the commit edge; reset clears balances and restores LIMIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_ENTRIES; i++) bal_q[i] <= '0;
            limit_q <= LIMIT_RST;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (bal_we && (wr_bal_idx == IDX_W'(i))) bal_q[i] <= wr_merged;
            end
            if (limit_we) limit_q <= wr_merged;
        end
    end

    // Read mux; unmapped words return zero data with DECERR.
    always_comb begin
        rd_data_o = '0;
        rd_resp_o = RESP_DECERR;
        if (rd_is_bal) begin
            rd_data_o = bal_q[rd_bal_idx];
            rd_resp_o = RESP_OKAY;
        end else if (rd_is_limit) begin
            rd_data_o = limit_q;
            rd_resp_o = RESP_OKAY;
        end else if (rd_is_vcnt) begin
            rd_data_o = {16'h0000, vcnt_i};
            rd_resp_o = RESP_OKAY;
        end
    end

endmodule

// File: rtl/axil_charge_resp.sv
// AXI4-Lite slave front end for the charge-balance register block. Holds the
// independent write and read FSMs plus the violation counter; storage lives in
// chg_regfile. Optional feature: CHG_POLICY_CHECK_EN enables the over-limit
// policy check, the policy_violation pulse and the saturating violation_cnt.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. Readies depend only on FSM state (never on the matching valid); valids
// and their payloads are held stable from assertion until their handshake.
module axil_charge_resp
    import chg_pkg::*;
#(
    parameter int          N_ENTRIES = 16,
    parameter logic [31:0] LIMIT_RST = 32'hFFFF_FFFF
) (
    input  logic        asclk,
    input  logic        aresetn,
    input  logic [7:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [7:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        policy_violation,
    output logic [15:0] violation_cnt
);

    w_state_t    w_state_q, w_state_d;
    r_state_t    r_state_q, r_state_d;
    logic        ready_en_q;
    logic [5:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        latch_aw, latch_w, commit;
    logic [5:0]  cm_idx;
    logic [31:0] cm_data;
    logic [3:0]  cm_strb;
    logic        ar_hs;
    logic [1:0]  rf_wr_resp, rf_rd_resp;
    logic [31:0] rf_rd_data;
    logic        rf_violation;
    logic [15:0] vcnt;
    logic        unused_addr_lsbs;

    // Byte offset within a word is ignored on both address channels.
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Readies stay low until the first rising edge after reset release.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) ready_en_q <= 1'b0;
        else          ready_en_q <= 1'b1;
    end

    // Write FSM next state, channel readies and commit selection.
    always_comb begin
        w_state_d = w_state_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        latch_aw  = 1'b0;
        latch_w   = 1'b0;
        commit    = 1'b0;
        cm_idx    = aw_idx_q;
        cm_data   = wdata_q;
        cm_strb   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                s_awready = ready_en_q;
                s_wready  = ready_en_q;
                if (ready_en_q && s_awvalid && s_wvalid) begin
                    commit    = 1'b1;
                    cm_idx    = s_awaddr[7:2];
                    cm_data   = s_wdata;
                    cm_strb   = s_wstrb;
                    w_state_d = W_RESP;
                end else if (ready_en_q && s_awvalid) begin
                    latch_aw  = 1'b1;
                    w_state_d = W_HAVE_AW;
                end else if (ready_en_q && s_wvalid) begin
                    latch_w   = 1'b1;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    commit    = 1'b1;
                    cm_data   = s_wdata;
                    cm_strb   = s_wstrb;
                    w_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                s_awready = 1'b1;
                if (s_awvalid) begin
                    commit    = 1'b1;
                    cm_idx    = s_awaddr[7:2];
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state, half-transaction holding registers and response code.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            if (latch_aw) aw_idx_q <= s_awaddr[7:2];
            if (latch_w) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (commit) bresp_q <= rf_wr_resp;
        end
    end

    assign s_bvalid = (w_state_q == W_RESP);
    assign s_bresp  = bresp_q;

    // Read FSM next state and address ready.
    always_comb begin
        r_state_d = r_state_q;
        s_arready = 1'b0;
        ar_hs     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_arready = ready_en_q;
                if (ready_en_q && s_arvalid) begin
                    ar_hs     = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data is captured on the AR edge, so a same-edge write is not visible.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                rdata_q <= rf_rd_data;
                rresp_q <= rf_rd_resp;
            end
        end
    end

    assign s_rvalid = (r_state_q == R_DATA);
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;

    chg_regfile #(
        .N_ENTRIES (N_ENTRIES),
        .LIMIT_RST (LIMIT_RST)
    ) u_regfile (
        .clk_i       (asclk),
        .rst_ni      (aresetn),
        .wr_en_i     (commit),
        .wr_idx_i    (cm_idx),
        .wr_data_i   (cm_data),
        .wr_strb_i   (cm_strb),
        .wr_resp_o   (rf_wr_resp),
        .violation_o (rf_violation),
        .rd_idx_i    (s_araddr[7:2]),
        .vcnt_i      (vcnt),
        .rd_data_o   (rf_rd_data),
        .rd_resp_o   (rf_rd_resp)
    );

`ifdef CHG_POLICY_CHECK_EN
    logic [15:0] vcnt_q;

    // Saturating count of rejected writes.
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            vcnt_q <= '0;
        end else if (rf_violation && (vcnt_q != 16'hFFFF)) begin
            vcnt_q <= vcnt_q + 16'd1;
        end
    end

    assign vcnt             = vcnt_q;
    assign policy_violation = rf_violation;
`else
    assign vcnt             = 16'h0000;
    assign policy_violation = 1'b0;
`endif

    assign violation_cnt = vcnt;

endmodule

// File: tb/tb_axil_charge_resp.sv
// Directed bench for axil_charge_resp: a table of single write/read
// transactions with hand-computed results, then hand-written sequences for
// out-of-order channels, response back-pressure, read/write collision,
// the policy check (when CHG_POLICY_CHECK_EN is defined) and mid-flight reset.
module tb_axil_charge_resp;

    logic        clk;
    logic        aresetn;
    logic [7:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [7:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        policy_violation;
    logic [15:0] violation_cnt;

    int n_checks  = 0;
    int n_errors  = 0;
    int pulse_cnt = 0;

    axil_charge_resp dut (
        .asclk            (clk),
        .aresetn          (aresetn),
        .s_awaddr         (s_awaddr),
        .s_awvalid        (s_awvalid),
        .s_awready        (s_awready),
        .s_wdata          (s_wdata),
        .s_wstrb          (s_wstrb),
        .s_wvalid         (s_wvalid),
        .s_wready         (s_wready),
        .s_bresp          (s_bresp),
        .s_bvalid         (s_bvalid),
        .s_bready         (s_bready),
        .s_araddr         (s_araddr),
        .s_arvalid        (s_arvalid),
        .s_arready        (s_arready),
        .s_rdata          (s_rdata),
        .s_rresp          (s_rresp),
        .s_rvalid         (s_rvalid),
        .s_rready         (s_rready),
        .policy_violation (policy_violation),
        .violation_cnt    (violation_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count policy_violation pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (policy_violation) pulse_cnt <= pulse_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    // ---------------- driver tasks ----------------
    // Write with AW and W presented together, bready held high.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        @(negedge clk);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        s_bready = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge clk);
            @(negedge clk);
            if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_wvalid = 1'b0; end
            cyc++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        resp = 2'bxx;
        if (!(aw_done && w_done)) begin
            timeout_fail("write_addr_data");
        end else begin
            cyc = 0;
            while (!s_bvalid && cyc < 20) begin @(negedge clk); cyc++; end
            if (!s_bvalid) begin
                timeout_fail("write_resp");
            end else begin
                resp = s_bresp;
                @(posedge clk);
                @(negedge clk);
            end
        end
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int cyc;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        data = 'x; resp = 2'bxx;
        cyc = 0;
        while (!s_arready && cyc < 20) begin @(negedge clk); cyc++; end
        if (!s_arready) begin
            timeout_fail("read_addr");
            s_arvalid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            s_arvalid = 1'b0;
            cyc = 0;
            while (!s_rvalid && cyc < 20) begin @(negedge clk); cyc++; end
            if (!s_rvalid) begin
                timeout_fail("read_data");
            end else begin
                data = s_rdata;
                resp = s_rresp;
                @(posedge clk);
                @(negedge clk);
            end
        end
        s_rready = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [7:0] addr,
                               input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        do_read(addr, d, r);
        check({name, "_rdata"}, d, exp_data);
        check({name, "_rresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic write_expect(input string name, input logic [7:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        do_write(addr, data, strb, r);
        check({name, "_bresp"}, 32'(r), 32'(exp_resp));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int base;

        // W: {1, addr, wdata, strb, bresp, -}; R: {0, addr, -, -, rresp, rdata}
        vecs[0]  = '{1'b1, 8'h0C, 32'h0000_0064, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 2'b00, 32'h0000_0064};
        vecs[2]  = '{1'b1, 8'h0D, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 8'h0E, 32'h0,         4'h0, 2'b00, 32'h00BB_00DD};
        vecs[4]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 2'b00, 32'h00BB_00DD};
        vecs[6]  = '{1'b1, 8'h3C, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 8'h3F, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
        vecs[8]  = '{1'b0, 8'h40, 32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
        vecs[9]  = '{1'b0, 8'h44, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[10] = '{1'b1, 8'h44, 32'h0000_1234, 4'hF, 2'b10, 32'h0};
        vecs[11] = '{1'b0, 8'h44, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 8'h50, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[13] = '{1'b1, 8'h50, 32'h0000_DEAD, 4'hF, 2'b11, 32'h0};
        vecs[14] = '{1'b0, 8'h48, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[15] = '{1'b1, 8'h40, 32'h0000_0200, 4'h3, 2'b00, 32'h0};
        vecs[16] = '{1'b0, 8'h40, 32'h0,         4'h0, 2'b00, 32'hFFFF_0200};
        vecs[17] = '{1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[18] = '{1'b0, 8'hFC, 32'h0,         4'h0, 2'b11, 32'h0};

        // ---------------- reset ----------------
        aresetn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(s_awready), 32'h0);
        check("rst_wready",  32'(s_wready),  32'h0);
        check("rst_arready", 32'(s_arready), 32'h0);
        check("rst_bvalid",  32'(s_bvalid),  32'h0);
        check("rst_rvalid",  32'(s_rvalid),  32'h0);
        check("rst_rdata",   s_rdata,        32'h0);
        check("rst_vcnt",    32'(violation_cnt), 32'h0);
        check("rst_pviol",   32'(policy_violation), 32'h0);
        aresetn = 1'b1;
        #1;
        check("rel_awready_early", 32'(s_awready), 32'h0);
        check("rel_arready_early", 32'(s_arready), 32'h0);
        @(negedge clk);
        check("rel_awready", 32'(s_awready), 32'h1);
        check("rel_wready",  32'(s_wready),  32'h1);
        check("rel_arready", 32'(s_arready), 32'h1);

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end
        end

        // ---------------- W three cycles before AW, bready held low ----------------
        @(negedge clk);
        s_wdata = 32'h0000_0055; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_wvalid = 1'b0;
        check("wfirst_wready_low", 32'(s_wready), 32'h0);
        check("wfirst_awready",    32'(s_awready), 32'h1);
        repeat (2) @(negedge clk);
        check("wfirst_no_bvalid",  32'(s_bvalid), 32'h0);
        s_awaddr = 8'h08; s_awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wfirst_bvalid_hold%0d", k), 32'(s_bvalid), 32'h1);
            check($sformatf("wfirst_bresp_hold%0d", k),  32'(s_bresp),  32'h0);
            check($sformatf("wfirst_awready_low%0d", k), 32'(s_awready), 32'h0);
            @(negedge clk);
        end
        s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0;
        check("wfirst_bvalid_done", 32'(s_bvalid), 32'h0);
        read_expect("wfirst_word2", 8'h08, 32'h0000_0055, 2'b00);

        // ---------------- write commit and read of the same word on one edge ----------------
        @(negedge clk);
        s_awaddr = 8'h14; s_awvalid = 1'b1;
        s_wdata = 32'h0000_00AA; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 8'h14; s_arvalid = 1'b1;
        s_bready = 1'b0; s_rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("coll_rvalid", 32'(s_rvalid), 32'h1);
        check("coll_rdata_prior", s_rdata, 32'h0);
        check("coll_bvalid", 32'(s_bvalid), 32'h1);
        check("coll_bresp",  32'(s_bresp),  32'h0);
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        read_expect("coll_after", 8'h14, 32'h0000_00AA, 2'b00);

        // ---------------- policy check ----------------
`ifdef CHG_POLICY_CHECK_EN
        write_expect("pol_limit", 8'h40, 32'h0000_0100, 4'hF, 2'b00);
        base = pulse_cnt;
        write_expect("pol_over", 8'h00, 32'h0000_0101, 4'hF, 2'b10);
        check("pol_pulses", 32'(pulse_cnt - base), 32'h1);
        check("pol_vcnt", 32'(violation_cnt), 32'h1);
        read_expect("pol_bal0_kept", 8'h00, 32'h0, 2'b00);
        read_expect("pol_vcnt_rd", 8'h44, 32'h1, 2'b00);
        write_expect("pol_at_limit", 8'h00, 32'h0000_0100, 4'hF, 2'b00);
        read_expect("pol_bal0_new", 8'h00, 32'h0000_0100, 2'b00);
        check("pol_pulses_total", 32'(pulse_cnt - base), 32'h1);
`else
        base = 0;
        write_expect("nopol_limit", 8'h40, 32'h0000_0100, 4'hF, 2'b00);
        write_expect("nopol_over", 8'h00, 32'h0000_0101, 4'hF, 2'b00);
        read_expect("nopol_bal0", 8'h00, 32'h0000_0101, 2'b00);
        check("nopol_pulses", 32'(pulse_cnt - base), 32'h0);
        check("nopol_vcnt", 32'(violation_cnt), 32'h0);
`endif

        // ---------------- reset while a write response is pending ----------------
        @(negedge clk);
        s_awaddr = 8'h04; s_awvalid = 1'b1;
        s_wdata = 32'h0000_0077; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("mid_bvalid_before", 32'(s_bvalid), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_bvalid_async",  32'(s_bvalid),  32'h0);
        check("mid_awready_async", 32'(s_awready), 32'h0);
        check("mid_arready_async", 32'(s_arready), 32'h0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_resp_after", 32'(s_bvalid), 32'h0);
        read_expect("mid_bal1", 8'h04, 32'h0, 2'b00);
        read_expect("mid_bal3", 8'h0C, 32'h0, 2'b00);
        read_expect("mid_bal5", 8'h14, 32'h0, 2'b00);
        read_expect("mid_limit", 8'h40, 32'hFFFF_FFFF, 2'b00);
        read_expect("mid_vcnt", 8'h44, 32'h0, 2'b00);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
